// File: rtl/sgdh_light_output_driver_pkg.sv
// Shared lamp codes, counter widths and helpers for the light output driver.
package sgdh_light_output_driver_pkg;

    // One-hot lamp codes shared with the traffic-light core
    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;
    localparam logic [2:0] LIGHT_DARK   = 3'b000;

    localparam int CHANGE_CNT_WIDTH = 16;

    // Driver FSM: normal lamp display, or yellow flash while the input is corrupt
    typedef enum logic {
        S_NORMAL = 1'b0,
        S_FAULT  = 1'b1
    } drv_state_e;

    // A code is legal when it is dark or exactly one lamp is lit
    function automatic logic is_legal_light(input logic [2:0] code);
        logic legal;
        case (code)
            LIGHT_RED, LIGHT_YELLOW, LIGHT_GREEN, LIGHT_DARK: legal = 1'b1;
            default:                                          legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CHANGE_CNT_WIDTH-1:0] sat_inc_cnt(
        input logic [CHANGE_CNT_WIDTH-1:0] value
    );
        return (&value) ? value : value + CHANGE_CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/sgdh_light_output_driver_pwm_gen.sv
// Free-running PWM counter and duty compare used to dim the lamps.
module sgdh_light_output_driver_pwm_gen #(
    parameter int PWM_BITS = 8
) (
    input  logic                i_clk,
    input  logic                i_areset,
    input  logic [PWM_BITS-1:0] i_brightness,
    output logic                o_pwm_on
);

    logic [PWM_BITS-1:0] r_pwm_cnt;

    // Counter only restarts on reset; a brightness change never restarts it
    always_ff @(posedge i_clk) begin
        if (i_areset) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
        end
    end

    // All-ones duty is forced fully on, since the compare alone tops out one short
    assign o_pwm_on = (&i_brightness) | (r_pwm_cnt < i_brightness);

endmodule

// File: rtl/sgdh_light_output_driver.sv
// Drives the three lamp pins from the core's one-hot light bus: PWM dimming,
// glitch filtering of short illegal codes, a flashing-yellow fault state for
// persistent illegal codes, and a saturating count of legal lamp changes.
//
// The light bus has no handshake: it is sampled every cycle, and every output
// is registered, so a code shows on the pins one cycle after it is sampled.
module sgdh_light_output_driver
    import sgdh_light_output_driver_pkg::*;
#(
    parameter int PWM_BITS     = 8,
    parameter int BLINK_HALF   = 4,
    parameter int FAULT_HOLD   = 3,
    parameter int RECOVER_TIME = 4
) (
    input  logic                        clk,
    input  logic                        areset,
    input  logic [2:0]                  light,
    input  logic [PWM_BITS-1:0]         brightness,
    output logic                        led_r,
    output logic                        led_y,
    output logic                        led_g,
    output logic                        fault,
    output logic [CHANGE_CNT_WIDTH-1:0] change_cnt
);

    // Reject parameterisations that would make the counters meaningless
    if (PWM_BITS < 1) begin : g_chk_pwm_bits
        $error("sgdh_light_output_driver: PWM_BITS must be >= 1");
    end
    if (BLINK_HALF < 1) begin : g_chk_blink_half
        $error("sgdh_light_output_driver: BLINK_HALF must be >= 1");
    end
    if (FAULT_HOLD < 1) begin : g_chk_fault_hold
        $error("sgdh_light_output_driver: FAULT_HOLD must be >= 1");
    end
    if (RECOVER_TIME < 1) begin : g_chk_recover_time
        $error("sgdh_light_output_driver: RECOVER_TIME must be >= 1");
    end

    drv_state_e                  r_state;
    logic [2:0]                  r_last_legal;
    logic [31:0]                 r_bad_cnt;
    logic [31:0]                 r_good_cnt;
    logic [31:0]                 r_blink_cnt;
    logic                        r_blink_phase;
    logic                        r_led_r;
    logic                        r_led_y;
    logic                        r_led_g;
    logic                        r_fault;
    logic [CHANGE_CNT_WIDTH-1:0] r_change_cnt;

    logic                        w_pwm_on;
    logic                        w_legal;
    logic [2:0]                  w_show;
    logic                        w_blink_wrap;
    logic                        w_phase_next;

    sgdh_light_output_driver_pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm_gen (
        .i_clk        (clk),
        .i_areset     (areset),
        .i_brightness (brightness),
        .o_pwm_on     (w_pwm_on)
    );

    assign w_legal      = is_legal_light(light);
    // Short illegal bursts are hidden by redisplaying the last legal code
    assign w_show       = (w_legal ? light : r_last_legal) & {3{w_pwm_on}};
    assign w_blink_wrap = (r_blink_cnt == 32'(BLINK_HALF - 1));
    assign w_phase_next = w_blink_wrap ? ~r_blink_phase : r_blink_phase;

    // Driver FSM with all lamp, fault and counter outputs registered
    always_ff @(posedge clk) begin
        if (areset) begin
            r_state       <= S_NORMAL;
            r_last_legal  <= LIGHT_DARK;
            r_bad_cnt     <= '0;
            r_good_cnt    <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_led_r       <= 1'b0;
            r_led_y       <= 1'b0;
            r_led_g       <= 1'b0;
            r_fault       <= 1'b0;
            r_change_cnt  <= '0;
        end else begin
            case (r_state)
                S_NORMAL: begin
                    if (w_legal) begin
                        r_bad_cnt    <= '0;
                        r_last_legal <= light;
                        if ((light != LIGHT_DARK) && (light != r_last_legal)) begin
                            r_change_cnt <= sat_inc_cnt(r_change_cnt);
                        end
                        {r_led_r, r_led_y, r_led_g} <= w_show;
                    end else if (r_bad_cnt == 32'(FAULT_HOLD - 1)) begin
                        // Persistent corruption: start flashing with yellow lit at once
                        r_state       <= S_FAULT;
                        r_fault       <= 1'b1;
                        r_bad_cnt     <= '0;
                        r_good_cnt    <= '0;
                        r_blink_cnt   <= '0;
                        r_blink_phase <= 1'b1;
                        {r_led_r, r_led_y, r_led_g} <= LIGHT_YELLOW;
                    end else begin
                        r_bad_cnt <= r_bad_cnt + 32'd1;
                        {r_led_r, r_led_y, r_led_g} <= w_show;
                    end
                end
                S_FAULT: begin
                    // Yellow flashes at full brightness, ignoring the PWM duty
                    r_blink_cnt   <= w_blink_wrap ? '0 : r_blink_cnt + 32'd1;
                    r_blink_phase <= w_phase_next;
                    r_led_r       <= 1'b0;
                    r_led_y       <= w_phase_next;
                    r_led_g       <= 1'b0;
                    if (!w_legal) begin
                        r_good_cnt <= '0;
                    end else if (r_good_cnt == 32'(RECOVER_TIME - 1)) begin
                        // Clean again: show this input immediately, without counting it as a change
                        r_state      <= S_NORMAL;
                        r_fault      <= 1'b0;
                        r_good_cnt   <= '0;
                        r_bad_cnt    <= '0;
                        r_last_legal <= light;
                        {r_led_r, r_led_y, r_led_g} <= light & {3{w_pwm_on}};
                    end else begin
                        r_good_cnt <= r_good_cnt + 32'd1;
                    end
                end
                default: begin
                    r_state <= S_NORMAL;
                end
            endcase
        end
    end

    assign led_r      = r_led_r;
    assign led_y      = r_led_y;
    assign led_g      = r_led_g;
    assign fault      = r_fault;
    assign change_cnt = r_change_cnt;

endmodule
